pipe_trace_monitor: RTL and testbench
=====================================

PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of captured writeback data and PC.
REQ-002 SHALL have parameter DEPTH, default 16, a power of two ≥ 2: number of trace entries.
REQ-003 SHALL have parameter WRAP, default 0: 0 = drop on full; 1 = overwrite oldest.
REQ-004 SHALL have parameter HALT_CYCLES, default 8, ≥ 2: cycles of unchanged PC that declare a halt.
REQ-005 SHALL have port Clk, input, 1: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port Rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port pc_in, input, DATA_W: current fetch PC.
REQ-008 SHALL have port wb_en, input, 1: writeback-stage register write this cycle.
REQ-009 SHALL have port wb_reg, input, 5: destination register number.
REQ-010 SHALL have port wb_data, input, DATA_W: destination register value.
REQ-011 SHALL have port clr, input, 1: synchronous clear of halt, overflow and cycle counter; trace contents are kept.
REQ-012 SHALL have port rd_ack, input, 1: pops the head entry when rd_valid is high.
REQ-013 SHALL have port rd_valid, output, 1: the head entry is present.
REQ-014 SHALL have ports rd_pc (DATA_W), rd_reg (5) and rd_data (DATA_W), outputs: head entry fields.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1: entries held.
REQ-016 SHALL have port overflow, output, 1: sticky; an entry was lost or overwritten.
REQ-017 SHALL have port halted, output, 1: sticky; a halt was detected.
REQ-018 SHALL have port cycles, output, 32: cycles since reset or clr, saturating.

Function
REQ-019 SHALL capture a capture event, defined as wb_en=1 and halted=0 at a rising edge; each event stores {pc_in, wb_reg, wb_data} sampled at that edge.
REQ-020 SHALL make a captured entry visible on the rd_* outputs on the cycle after capture, with rd_valid = (count != 0).
REQ-021 SHALL present the head entry on rd_* combinationally from the read pointer, in show-ahead fashion.
REQ-022 SHALL pop the head entry on rd_ack=1 with rd_valid=1, and SHALL ignore rd_ack when rd_valid=0.
REQ-023 SHALL, on simultaneous capture and pop when not full, perform both and leave count unchanged.
REQ-024 SHALL, on simultaneous capture and pop when full, perform both, leave count at DEPTH and keep overflow unchanged.
REQ-025 SHALL, when WRAP=0 and the buffer is full with no pop, discard the capture and set overflow=1.
REQ-026 SHALL, when WRAP=1 and the buffer is full with no pop, write the new entry, advance both pointers, keep count at DEPTH and set overflow=1.
REQ-027 SHALL wrap both pointers modulo DEPTH.
REQ-028 SHALL implement a halt detector: the run counter increments when pc_in equals its value on the previous cycle, and otherwise resets to 0.
REQ-029 SHALL set halted=1 when the run counter reaches HALT_CYCLES-1.
REQ-030 SHALL, once halted=1, block further captures; pops still operate.
REQ-031 SHALL increment cycles every cycle while halted=0, saturate at 32'hFFFFFFFF, and freeze while halted=1.
REQ-032 SHALL, on clr=1, zero halted, overflow, cycles and the run counter on that edge; capture and pop in the same cycle proceed as normal.

Reset
REQ-033 SHALL, on Rst=1 and independent of Clk, clear: pointers, count=0, rd_valid=0, overflow=0, halted=0, cycles=0, run counter=0, previous-PC register=0.
REQ-034 SHALL drive rd_pc, rd_reg and rd_data to 0 during reset; storage contents need not be cleared.
REQ-035 SHALL make a reset asserted mid-operation discard all entries and take effect immediately, and SHALL allow capture on the first rising edge after Rst deasserts.

Configuration
REQ-036 SHALL, when macro TRACE_FILTER_EN is defined, exclude writebacks with wb_reg=0 from capture events; these neither store an entry nor affect overflow.
REQ-037 SHALL, when TRACE_FILTER_EN is undefined, capture every wb_en=1 cycle, including wb_reg=0.

Verification
REQ-038 SHALL cover basic capture: pc_in=0x4, wb_en=1, wb_reg=8, wb_data=0x2A for one cycle -> next cycle rd_valid=1, rd_pc=0x4, rd_reg=8, rd_data=0x2A, count=1; then rd_ack -> count=0.
REQ-039 SHALL cover full, drop mode: WRAP=0, DEPTH=4, 5 captures with data 1..5, no pops -> count=4, overflow=1, pops return 1,2,3,4.
REQ-040 SHALL cover full, wrap mode: WRAP=1, DEPTH=4, 5 captures with data 1..5 -> count=4, overflow=1, pops return 2,3,4,5.
REQ-041 SHALL cover halt: HALT_CYCLES=8, pc_in held at 0x40 with wb_en=1 -> halted=1 after the 7th repeat, further captures ignored, cycles frozen; clr -> halted=0, cycles=0.
REQ-042 SHALL cover filter: TRACE_FILTER_EN defined, wb_reg=0 then wb_reg=3 -> count=1, rd_reg=3; with the macro undefined -> count=2.
REQ-043 SHALL cover reset mid-stream: count=3, Rst pulsed between edges -> count=0, rd_valid=0 immediately, with no Clk edge required.

Source files
------------

// File: rtl/pipe_trace_monitor.sv
// Writeback trace buffer with halt detection and free-running cycle counter.
// Optional macro TRACE_FILTER_EN drops writebacks to register 0 from the trace.
module pipe_trace_monitor #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WRAP        = 0,
    parameter int HALT_CYCLES = 8
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic                       wb_en,
    input  logic [4:0]                 wb_reg,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       clr,
    input  logic                       rd_ack,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [4:0]                 rd_reg,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       halted,
    output logic [31:0]                cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(HALT_CYCLES) + 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(HALT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam bit WRAP_EN = (WRAP != 0);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              halted_q, halted_d;
    logic [31:0]       cycles_q, cycles_d;
    logic [RW-1:0]     run_q, run_d;
    logic [DATA_W-1:0] prev_pc_q, prev_pc_d;

    logic [DATA_W-1:0] pc_mem   [DEPTH];
    logic [4:0]        reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic filt_pass;
    logic cap;
    logic pop;
    logic full;
    logic wr_en;
    logic rd_adv;

`ifdef TRACE_FILTER_EN
    assign filt_pass = (wb_reg != 5'd0);
`else
    assign filt_pass = 1'b1;
`endif

    always_comb begin
        cap    = wb_en & ~halted_q & filt_pass;
        pop    = rd_ack & (count_q != '0);
        full   = (count_q == FULL_CNT);
        // A full buffer still accepts a capture when a pop frees a slot, or in wrap mode.
        wr_en  = cap & (pop | ~full | WRAP_EN);
        rd_adv = pop | (cap & full & WRAP_EN);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;
        cycles_d   = cycles_q;
        run_d      = run_q;
        prev_pc_d  = pc_in;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (cap && !pop && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !cap) begin
            count_d = count_q - 1'b1;
        end

        if (pc_in == prev_pc_q) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end else begin
            run_d = '0;
        end

        overflow_d = overflow_q | (cap & full & ~pop);
        halted_d   = halted_q | (run_d == RUN_MAX);
        if (!halted_q && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end

        // Clear wins over every sticky status update on the same edge.
        if (clr) begin
            overflow_d = 1'b0;
            halted_d   = 1'b0;
            cycles_d   = '0;
            run_d      = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
            cycles_q   <= '0;
            run_q      <= '0;
            prev_pc_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
            cycles_q   <= cycles_d;
            run_q      <= run_d;
            prev_pc_q  <= prev_pc_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]   <= pc_in;
            reg_mem[wr_ptr_q]  <= wb_reg;
            data_mem[wr_ptr_q] <= wb_data;
        end
    end

    // Gating on rd_valid keeps the head fields at zero while empty or in reset.
    assign rd_valid = (count_q != '0);
    assign rd_pc    = rd_valid ? pc_mem[rd_ptr_q]   : '0;
    assign rd_reg   = rd_valid ? reg_mem[rd_ptr_q]  : '0;
    assign rd_data  = rd_valid ? data_mem[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign halted   = halted_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench: a drop-mode and a wrap-mode instance (DEPTH=4) share one stimulus stream.
module tb_pipe_trace_monitor;

    logic        Clk;
    logic        Rst;
    logic [31:0] pc_in;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        clr;
    logic        rd_ack;

    logic        d_valid, w_valid;
    logic [31:0] d_pc, w_pc, d_data, w_data;
    logic [4:0]  d_reg, w_reg;
    logic [2:0]  d_count, w_count;
    logic        d_ovf, w_ovf, d_halted, w_halted;
    logic [31:0] d_cycles, w_cycles;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef TRACE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    pipe_trace_monitor #(.DATA_W(32), .DEPTH(4), .WRAP(0), .HALT_CYCLES(8)) dut_d (
        .Clk(Clk), .Rst(Rst), .pc_in(pc_in), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .clr(clr), .rd_ack(rd_ack), .rd_valid(d_valid),
        .rd_pc(d_pc), .rd_reg(d_reg), .rd_data(d_data), .count(d_count),
        .overflow(d_ovf), .halted(d_halted), .cycles(d_cycles)
    );

    pipe_trace_monitor #(.DATA_W(32), .DEPTH(4), .WRAP(1), .HALT_CYCLES(8)) dut_w (
        .Clk(Clk), .Rst(Rst), .pc_in(pc_in), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .clr(clr), .rd_ack(rd_ack), .rd_valid(w_valid),
        .rd_pc(w_pc), .rd_reg(w_reg), .rd_data(w_data), .count(w_count),
        .overflow(w_ovf), .halted(w_halted), .cycles(w_cycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] dat;
        logic        ack;
        logic        clr;
        logic [31:0] pc;
        logic [2:0]  d_cnt;
        logic [31:0] d_head;
        logic        d_ovf;
        logic [2:0]  w_cnt;
        logic [31:0] w_head;
        logic        w_ovf;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic en, input logic [4:0] rg, input logic [31:0] dat,
                                input logic ack, input logic c, input logic [31:0] pc,
                                input logic [2:0] dc, input logic [31:0] dh, input logic dov,
                                input logic [2:0] wc, input logic [31:0] wh, input logic wov);
        vec_t v;
        v.en = en; v.rg = rg; v.dat = dat; v.ack = ack; v.clr = c; v.pc = pc;
        v.d_cnt = dc; v.d_head = dh; v.d_ovf = dov;
        v.w_cnt = wc; v.w_head = wh; v.w_ovf = wov;
        return v;
    endfunction

    // Capture rows use pc = 0x100 + 4*data and reg = data; idle rows use 0x300 + 4*row.
    function automatic logic [31:0] cpc(input int k);
        return 32'h100 + 32'(4 * k);
    endfunction

    function automatic logic [31:0] ipc(input int r);
        return 32'h300 + 32'(4 * r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic en, input logic [31:0] pc, input logic [4:0] rg,
                         input logic [31:0] dat, input logic ack, input logic c);
        wb_en = en; pc_in = pc; wb_reg = rg; wb_data = dat; rd_ack = ack; clr = c;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] epc;
        logic [4:0]  ereg;

        tbl[0]  = mk(1, 8, 32'h2A, 0, 0, 32'h4, 1, 32'h2A, 0, 1, 32'h2A, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0, ipc(1),  0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 1, 0, 0, cpc(1),  1, 1, 0, 1, 1, 0);
        tbl[3]  = mk(1, 2, 2, 0, 0, cpc(2),  2, 1, 0, 2, 1, 0);
        tbl[4]  = mk(1, 3, 3, 0, 0, cpc(3),  3, 1, 0, 3, 1, 0);
        tbl[5]  = mk(1, 4, 4, 0, 0, cpc(4),  4, 1, 0, 4, 1, 0);
        tbl[6]  = mk(1, 5, 5, 0, 0, cpc(5),  4, 1, 1, 4, 2, 1);
        tbl[7]  = mk(0, 0, 0, 1, 0, ipc(7),  3, 2, 1, 3, 3, 1);
        tbl[8]  = mk(0, 0, 0, 1, 0, ipc(8),  2, 3, 1, 2, 4, 1);
        tbl[9]  = mk(1, 6, 6, 1, 0, cpc(6),  2, 4, 1, 2, 5, 1);
        tbl[10] = mk(0, 0, 0, 1, 0, ipc(10), 1, 6, 1, 1, 6, 1);
        tbl[11] = mk(1, 7, 7, 0, 1, cpc(7),  2, 6, 0, 2, 6, 0);
        tbl[12] = mk(1, 8, 8, 0, 0, cpc(8),  3, 6, 0, 3, 6, 0);
        tbl[13] = mk(1, 9, 9, 0, 0, cpc(9),  4, 6, 0, 4, 6, 0);
        tbl[14] = mk(1, 10, 10, 1, 0, cpc(10), 4, 7, 0, 4, 7, 0);
        tbl[15] = mk(0, 0, 0, 1, 0, ipc(15), 3, 8, 0, 3, 8, 0);
        tbl[16] = mk(0, 0, 0, 1, 0, ipc(16), 2, 9, 0, 2, 9, 0);
        tbl[17] = mk(0, 0, 0, 1, 0, ipc(17), 1, 10, 0, 1, 10, 0);
        tbl[18] = mk(0, 0, 0, 1, 0, ipc(18), 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 1, 0, ipc(19), 0, 0, 0, 0, 0, 0);

        Rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_valid", 32'(d_valid), 0);
        chk("rst_count", 32'(d_count), 0);
        chk("rst_ovf", 32'(d_ovf), 0);
        chk("rst_halted", 32'(d_halted), 0);
        chk("rst_cycles", d_cycles, 0);
        chk("rst_rd_pc", d_pc, 0);
        #1 Rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].en, tbl[i].pc, tbl[i].rg, tbl[i].dat, tbl[i].ack, tbl[i].clr);
            step();
            if (tbl[i].d_head == 32'h2A) begin
                epc = 32'h4; ereg = 5'd8;
            end else if (tbl[i].d_head == 0) begin
                epc = 0; ereg = 0;
            end else begin
                epc = 32'h100 + 4 * tbl[i].d_head; ereg = tbl[i].d_head[4:0];
            end
            chk($sformatf("r%0d_d_count", i), 32'(d_count), 32'(tbl[i].d_cnt));
            chk($sformatf("r%0d_d_valid", i), 32'(d_valid), 32'(tbl[i].d_cnt != 0));
            chk($sformatf("r%0d_d_data", i), d_data, tbl[i].d_head);
            chk($sformatf("r%0d_d_pc", i), d_pc, epc);
            chk($sformatf("r%0d_d_reg", i), 32'(d_reg), 32'(ereg));
            chk($sformatf("r%0d_d_ovf", i), 32'(d_ovf), 32'(tbl[i].d_ovf));
            chk($sformatf("r%0d_w_count", i), 32'(w_count), 32'(tbl[i].w_cnt));
            chk($sformatf("r%0d_w_data", i), w_data, tbl[i].w_head);
            chk($sformatf("r%0d_w_ovf", i), 32'(w_ovf), 32'(tbl[i].w_ovf));
            $display("vec %0d: en=%0b ack=%0b clr=%0b d_count=%0d d_data=0x%0h w_count=%0d w_data=0x%0h",
                     i, tbl[i].en, tbl[i].ack, tbl[i].clr, d_count, d_data, w_count, w_data);
        end

        // Register-0 filtering.
        drive(1, 32'h400, 0, 32'h55, 0, 0);
        step();
        drive(1, 32'h404, 3, 32'h66, 0, 0);
        step();
        chk("filt_count", 32'(d_count), FILT ? 32'd1 : 32'd2);
        chk("filt_reg", 32'(d_reg), FILT ? 32'd3 : 32'd0);
        chk("filt_data", d_data, FILT ? 32'h66 : 32'h55);
        $display("filter: count=%0d head_reg=%0d", d_count, d_reg);
        drive(0, 32'h408, 0, 0, 1, 0);
        step();
        drive(0, 32'h40C, 0, 0, 1, 0);
        step();
        chk("filt_drain", 32'(d_count), 0);

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h500 + 32'(4 * k), 5'(k + 1), 32'(k + 1), 0, 0);
            step();
        end
        chk("pre_rst_count", 32'(d_count), 3);
        drive(0, 32'h50C, 0, 0, 0, 0);
        #1 Rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(d_count), 0);
        chk("mid_rst_valid", 32'(d_valid), 0);
        chk("mid_rst_rd_pc", d_pc, 0);
        chk("mid_rst_rd_data", d_data, 0);
        chk("mid_rst_w_count", 32'(w_count), 0);
        $display("mid reset: count=%0d valid=%0b", d_count, d_valid);
        #1 Rst = 1'b0;
        drive(1, 32'h510, 7, 32'h77, 0, 0);
        step();
        chk("post_rst_count", 32'(d_count), 1);
        chk("post_rst_data", d_data, 32'h77);
        chk("post_rst_reg", 32'(d_reg), 7);
        drive(0, 32'h514, 0, 0, 1, 0);
        step();
        chk("post_rst_pop", 32'(d_count), 0);

        // Halt detection with PC held at 0x40.
        drive(0, 32'h3C, 0, 0, 0, 1);
        step();
        chk("halt_pre_cycles", d_cycles, 0);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 32'h40, 5'(k), 32'(k), 0, 0);
            step();
            chk($sformatf("halt_e%0d_halted", k), 32'(d_halted), 32'(k == 8));
            $display("halt edge %0d: halted=%0b cycles=%0d count=%0d", k, d_halted, d_cycles, d_count);
        end
        chk("halt_cycles", d_cycles, 8);
        chk("halt_count", 32'(d_count), 4);
        chk("halt_ovf", 32'(d_ovf), 1);
        chk("halt_w_halted", 32'(w_halted), 1);
        drive(1, 32'h40, 9, 9, 1, 0);
        step();
        chk("halt_pop_count", 32'(d_count), 3);
        chk("halt_pop_head", d_data, 2);
        chk("halt_frozen_cycles", d_cycles, 8);
        drive(1, 32'h40, 10, 10, 0, 0);
        step();
        chk("halt_blocked_count", 32'(d_count), 3);
        chk("halt_frozen_cycles2", d_cycles, 8);
        drive(1, 32'h40, 11, 11, 0, 1);
        step();
        chk("clr_halted", 32'(d_halted), 0);
        chk("clr_cycles", d_cycles, 0);
        chk("clr_ovf", 32'(d_ovf), 0);
        chk("clr_count", 32'(d_count), 3);
        chk("clr_w_cycles", w_cycles, 0);
        drive(0, 32'h44, 0, 0, 0, 0);
        step();
        chk("after_clr_cycles", d_cycles, 1);
        chk("after_clr_halted", 32'(d_halted), 0);
        $display("after clr: halted=%0b cycles=%0d", d_halted, d_cycles);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
